// File: rtl/grid_walk_retrace_if.sv
// Command/status bundle between the grid walker and its driver.
// The master drives moves and retrace requests; the slave reports position and retrace output.
interface grid_walk_retrace_if #(
    parameter int POS_W  = 5,
    parameter int STEP_W = 2,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              move_valid;
    logic              move_ready;
    logic              move_dir;
    logic              move_op;
    logic [STEP_W-1:0] move_step;
    logic              retrace_start;
    logic [POS_W-1:0]  x_pos;
    logic [POS_W-1:0]  y_pos;
    logic              retrace_valid;
    logic              retrace_dir;
    logic              retrace_op;
    logic [STEP_W-1:0] retrace_step;
    logic              busy;
    logic              done;
    logic              overflow_flag;
    logic [CW-1:0]     log_count;
    logic              log_full;

    modport master (
        output move_valid, move_dir, move_op, move_step, retrace_start,
        input  move_ready, x_pos, y_pos, retrace_valid, retrace_dir, retrace_op,
               retrace_step, busy, done, overflow_flag, log_count, log_full
    );

    modport slave (
        input  move_valid, move_dir, move_op, move_step, retrace_start,
        output move_ready, x_pos, y_pos, retrace_valid, retrace_dir, retrace_op,
               retrace_step, busy, done, overflow_flag, log_count, log_full
    );
endinterface

// File: rtl/grid_walk_retrace.sv
// Grid walker: applies X/Y moves, logs them in a LIFO, and on request replays
// the log in reverse with inverted ops to return to the last empty-log position.
module grid_walk_retrace #(
    parameter int POS_W  = 5,
    parameter int STEP_W = 2,
    parameter int DEPTH  = 16
) (
    input logic               clk,
    input logic               rst_n,
    grid_walk_retrace_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = STEP_W + 2;

    typedef enum logic [1:0] {IDLE, RETRACE, DONE} state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              rv_q, rv_d, rdir_q, rdir_d, rop_q, rop_d;
    logic [STEP_W-1:0] rstep_q, rstep_d;
    logic              done_q, done_d;
    logic [EW-1:0]     log_mem_q [DEPTH];

    logic              full, ready, push, pop;
    logic [EW-1:0]     top;
    logic              upd_en, upd_dir, upd_op;
    logic [STEP_W-1:0] upd_step;
    logic [POS_W-1:0]  upd_a, upd_b, upd_res;
    logic [POS_W-2:0]  sum_lo;
    logic              c_msb, c_out, sum_msb, upd_ovf;

    assign full  = (cnt_q == CW'(DEPTH));
    assign ready = (state_q == IDLE) && !full && !bus.retrace_start;
    assign push  = ready && bus.move_valid;
    assign top   = log_mem_q[cnt_q[AW-1:0] - AW'(1)];

    // Subtraction as a + ~b + 1 so overflow is the carry into vs out of the MSB.
    always_comb begin
        upd_a            = upd_dir ? y_q : x_q;
        upd_b            = upd_op ? ~POS_W'(upd_step) : POS_W'(upd_step);
        {c_msb, sum_lo}  = {1'b0, upd_a[POS_W-2:0]} + {1'b0, upd_b[POS_W-2:0]} + POS_W'(upd_op);
        {c_out, sum_msb} = 2'(upd_a[POS_W-1]) + 2'(upd_b[POS_W-1]) + 2'(c_msb);
        upd_res          = {sum_msb, sum_lo};
        upd_ovf          = c_msb ^ c_out;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        rv_d     = 1'b0;
        rdir_d   = rdir_q;
        rop_d    = rop_q;
        rstep_d  = rstep_q;
        done_d   = (state_q == DONE);
        pop      = 1'b0;
        upd_en   = 1'b0;
        upd_dir  = bus.move_dir;
        upd_op   = bus.move_op;
        upd_step = bus.move_step;
        case (state_q)
            IDLE: begin
                if (bus.retrace_start) state_d = (cnt_q != '0) ? RETRACE : DONE;
                else if (push)         upd_en  = 1'b1;
            end
            RETRACE: begin
                pop      = 1'b1;
                upd_en   = 1'b1;
                upd_dir  = top[EW-1];
                upd_op   = ~top[EW-2];
                upd_step = top[STEP_W-1:0];
                rv_d     = 1'b1;
                rdir_d   = top[EW-1];
                rop_d    = ~top[EW-2];
                rstep_d  = top[STEP_W-1:0];
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (upd_en) begin
            if (upd_dir) y_d = upd_res;
            else         x_d = upd_res;
            ovf_d = ovf_q | upd_ovf;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            rdir_q  <= 1'b0;
            rop_q   <= 1'b0;
            rstep_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
            rdir_q  <= rdir_d;
            rop_q   <= rop_d;
            rstep_q <= rstep_d;
            done_q  <= done_d;
        end
    end

    // Log storage needs no reset: entries above log_count are never read.
    always_ff @(posedge clk) begin
        if (push) log_mem_q[cnt_q[AW-1:0]] <= {bus.move_dir, bus.move_op, bus.move_step};
    end

    assign bus.move_ready    = ready;
    assign bus.x_pos         = x_q;
    assign bus.y_pos         = y_q;
    assign bus.retrace_valid = rv_q;
    assign bus.retrace_dir   = rdir_q;
    assign bus.retrace_op    = rop_q;
    assign bus.retrace_step  = rstep_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.log_count     = cnt_q;
    assign bus.log_full      = full;
endmodule

// File: tb/tb_grid_walk_retrace.sv
// Directed bench for grid_walk_retrace: moves, retrace replay, overflow, full log,
// start/move collision, empty retrace and asynchronous reset.
module tb_grid_walk_retrace;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    grid_walk_retrace_if bus ();
    grid_walk_retrace dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic d, input logic o, input logic [1:0] s);
        bus.move_valid = 1'b1;
        bus.move_dir   = d;
        bus.move_op    = o;
        bus.move_step  = s;
        #1;
        chk("move_ready", bus.move_ready, 1);
        tick();
        bus.move_valid = 1'b0;
    endtask

    task automatic start_retrace();
        bus.retrace_start = 1'b1;
        tick();
        bus.retrace_start = 1'b0;
    endtask

    task automatic ret_step(input string tag, input logic d, input logic o, input logic [1:0] s);
        tick();
        chk({tag, "_rv"}, bus.retrace_valid, 1);
        chk({tag, "_dir"}, bus.retrace_dir, d);
        chk({tag, "_op"}, bus.retrace_op, o);
        chk({tag, "_step"}, bus.retrace_step, s);
    endtask

    task automatic finish_check(input string tag);
        tick();
        chk({tag, "_rv_off"}, bus.retrace_valid, 0);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_cnt"}, bus.log_count, 0);
        tick();
        chk({tag, "_done_off"}, bus.done, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, bus.x_pos, 0);
        chk({tag, "_y"}, bus.y_pos, 0);
        chk({tag, "_cnt"}, bus.log_count, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rv"}, bus.retrace_valid, 0);
        chk({tag, "_ovf"}, bus.overflow_flag, 0);
        chk({tag, "_full"}, bus.log_full, 0);
    endtask

    initial begin
        bus.move_valid    = 1'b0;
        bus.move_dir      = 1'b0;
        bus.move_op       = 1'b0;
        bus.move_step     = 2'd0;
        bus.retrace_start = 1'b0;
        #2;
        chk_zero("rst_init");
        #10 rst_n = 1'b1;

        // 1: async reset mid-cycle
        do_move(1'b0, 1'b0, 2'd3);
        chk("t1_x", bus.x_pos, 3);
        chk("t1_cnt", bus.log_count, 1);
        #3 rst_n = 1'b0;
        #1 chk_zero("t1_async");
        #2 rst_n = 1'b1;

        // 2: +X3, +X2, -Y1, then retrace
        do_move(1'b0, 1'b0, 2'd3);
        do_move(1'b0, 1'b0, 2'd2);
        do_move(1'b1, 1'b1, 2'd1);
        chk("t2_x", bus.x_pos, 5);
        chk("t2_y", bus.y_pos, 5'b11111);
        chk("t2_cnt", bus.log_count, 3);
        chk("t2_ovf", bus.overflow_flag, 0);
        start_retrace();
        chk("t2_busy", bus.busy, 1);
        chk("t2_rv_pre", bus.retrace_valid, 0);
        ret_step("t2_p1", 1'b1, 1'b0, 2'd1);
        chk("t2_y_p1", bus.y_pos, 0);
        ret_step("t2_p2", 1'b0, 1'b1, 2'd2);
        chk("t2_x_p2", bus.x_pos, 3);
        ret_step("t2_p3", 1'b0, 1'b1, 2'd3);
        finish_check("t2_end");
        chk("t2_x_end", bus.x_pos, 0);
        chk("t2_y_end", bus.y_pos, 0);

        // 3: overflow, sticky through retrace
        for (int i = 0; i < 5; i++) do_move(1'b0, 1'b0, 2'd3);
        chk("t3_x15", bus.x_pos, 15);
        chk("t3_ovf_pre", bus.overflow_flag, 0);
        do_move(1'b0, 1'b0, 2'd1);
        chk("t3_x16", bus.x_pos, 5'b10000);
        chk("t3_ovf", bus.overflow_flag, 1);
        start_retrace();
        ret_step("t3_p1", 1'b0, 1'b1, 2'd1);
        chk("t3_x_p1", bus.x_pos, 15);
        for (int i = 0; i < 5; i++) ret_step("t3_pn", 1'b0, 1'b1, 2'd3);
        finish_check("t3_end");
        chk("t3_x_end", bus.x_pos, 0);
        chk("t3_ovf_end", bus.overflow_flag, 1);

        // 4: full log, held move ignored
        for (int i = 0; i < 8; i++) do_move(1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 8; i++) do_move(1'b1, 1'b0, 2'd1);
        chk("t4_cnt", bus.log_count, 16);
        chk("t4_full", bus.log_full, 1);
        chk("t4_ready", bus.move_ready, 0);
        bus.move_valid = 1'b1;
        bus.move_dir   = 1'b0;
        bus.move_op    = 1'b0;
        bus.move_step  = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_ready", bus.move_ready, 0);
            chk("t4_hold_x", bus.x_pos, 8);
            chk("t4_hold_y", bus.y_pos, 8);
            chk("t4_hold_cnt", bus.log_count, 16);
        end
        bus.move_valid = 1'b0;
        start_retrace();
        for (int i = 0; i < 8; i++) ret_step("t4_py", 1'b1, 1'b1, 2'd1);
        for (int i = 0; i < 8; i++) ret_step("t4_px", 1'b0, 1'b1, 2'd1);
        finish_check("t4_end");
        chk("t4_x_end", bus.x_pos, 0);
        chk("t4_y_end", bus.y_pos, 0);
        chk("t4_full_end", bus.log_full, 0);

        // 5a: retrace_start beats a simultaneous move
        do_move(1'b1, 1'b0, 2'd1);
        chk("t5a_y", bus.y_pos, 1);
        bus.move_valid    = 1'b1;
        bus.move_dir      = 1'b0;
        bus.move_op       = 1'b0;
        bus.move_step     = 2'd3;
        bus.retrace_start = 1'b1;
        #1 chk("t5a_ready", bus.move_ready, 0);
        tick();
        bus.move_valid    = 1'b0;
        bus.retrace_start = 1'b0;
        chk("t5a_busy", bus.busy, 1);
        ret_step("t5a_p1", 1'b1, 1'b1, 2'd1);
        finish_check("t5a_end");
        chk("t5a_x", bus.x_pos, 0);
        chk("t5a_y_end", bus.y_pos, 0);

        // 5b: retrace with empty log
        start_retrace();
        chk("t5b_busy", bus.busy, 1);
        chk("t5b_rv", bus.retrace_valid, 0);
        chk("t5b_done_pre", bus.done, 0);
        finish_check("t5b_end");

        // 6: reset after 2 of 4 pops
        do_move(1'b0, 1'b0, 2'd1);
        do_move(1'b0, 1'b0, 2'd2);
        do_move(1'b1, 1'b0, 2'd3);
        do_move(1'b1, 1'b0, 2'd1);
        chk("t6_x", bus.x_pos, 3);
        chk("t6_y", bus.y_pos, 4);
        start_retrace();
        ret_step("t6_p1", 1'b1, 1'b1, 2'd1);
        ret_step("t6_p2", 1'b1, 1'b1, 2'd3);
        chk("t6_cnt_mid", bus.log_count, 2);
        #3 rst_n = 1'b0;
        #1 chk_zero("t6_rst");
        #2 rst_n = 1'b1;
        do_move(1'b0, 1'b0, 2'd2);
        chk("t6_x_after", bus.x_pos, 2);
        chk("t6_cnt_after", bus.log_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
